// File: rtl/tx_merge_pkg.sv
// Shared definitions for the tx_merge slice: byte format, FSM encoding, pointer sizing.
package tx_merge_pkg;

    localparam int unsigned BYTE_W = 9;
    localparam int unsigned FV_BIT = 8;
    localparam int unsigned CNT_W  = 16;

    typedef logic [BYTE_W-1:0] mbyte_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_XFER  = 2'd1,
        S_ABORT = 2'd2
    } state_e;

    // Width of an index into n streams (at least one bit).
    function automatic int unsigned ptr_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tx_merge_rr_pick.sv
// Combinational round-robin selector: first requester at or after ptr, wrapping.
module rr_pick
    import tx_merge_pkg::*;
#(
    parameter int unsigned N  = 4,
    parameter int unsigned PW = ptr_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic          valid
);

    // Scan from ptr upward; the first hit wins.
    always_comb begin
        gnt   = '0;
        valid = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            if (!valid && req[PW'((32'(ptr) + k) % N)]) begin
                gnt[PW'((32'(ptr) + k) % N)] = 1'b1;
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tx_merge.sv
// Round-robin merge of NIN framed byte streams into one TX FIFO write port,
// with idle timeout that closes a dangling frame by writing 9'h000.
// Optional macro TXMERGE_STATS_EN adds per-input completed-frame counters (frame_cnt).
module tx_merge
    import tx_merge_pkg::*;
#(
    parameter int unsigned NIN     = 4,
    parameter logic [15:0] TIMEOUT = 16'd2048
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic [NIN-1:0]        in_req,
    output logic [NIN-1:0]        in_gnt,
    input  logic [NIN*BYTE_W-1:0] in_din,
    input  logic [NIN-1:0]        in_wr_en,
    output logic [NIN-1:0]        in_full,
    output logic [BYTE_W-1:0]     out_din,
    output logic                  out_wr_en,
    input  logic                  out_full,
    output logic [CNT_W-1:0]      abort_cnt
`ifdef TXMERGE_STATS_EN
    ,
    output logic [NIN*32-1:0]     frame_cnt
`endif
);

    localparam int unsigned PW = ptr_w(NIN);

    state_e           state, state_nx;
    logic [NIN-1:0]   gnt, gnt_nx;
    logic [PW-1:0]    gidx, gidx_nx;
    logic [PW-1:0]    rr_ptr, rr_nx;
    logic [PW-1:0]    ptr_inc;
    logic             sof, sof_nx;
    logic [CNT_W-1:0] idle_cnt, idle_nx;
    logic [CNT_W-1:0] abort_nx;
    mbyte_t           din_a [NIN];
    mbyte_t           cur;
    logic             accept;
    logic [NIN-1:0]   pick_gnt;
    logic             pick_valid;
    logic [PW-1:0]    pick_idx;
`ifdef TXMERGE_STATS_EN
    logic [31:0]      fc    [NIN];
    logic [31:0]      fc_nx [NIN];
`endif

    rr_pick #(.N(NIN), .PW(PW)) u_pick (
        .req   (in_req),
        .ptr   (rr_ptr),
        .gnt   (pick_gnt),
        .valid (pick_valid)
    );

    assign in_gnt  = gnt;
    assign ptr_inc = (gidx == PW'(NIN - 1)) ? '0 : gidx + PW'(1);

    // Unpack the flat input bus and encode the one-hot pick as an index.
    always_comb begin
        pick_idx = '0;
        for (int unsigned i = 0; i < NIN; i++) begin
            din_a[i] = in_din[i*BYTE_W +: BYTE_W];
            if (pick_gnt[i]) pick_idx = PW'(i);
        end
    end

`ifdef TXMERGE_STATS_EN
    // Flatten per-input frame counters onto the stats port.
    always_comb begin
        for (int unsigned i = 0; i < NIN; i++) frame_cnt[i*32 +: 32] = fc[i];
    end
`endif

    // Next-state, registered-next values and combinational datapath.
    always_comb begin
        state_nx  = state;
        gnt_nx    = gnt;
        gidx_nx   = gidx;
        rr_nx     = rr_ptr;
        sof_nx    = sof;
        idle_nx   = idle_cnt;
        abort_nx  = abort_cnt;
        cur       = din_a[gidx];
        accept    = 1'b0;
        out_din   = '0;
        out_wr_en = 1'b0;
        in_full   = '1;
`ifdef TXMERGE_STATS_EN
        fc_nx     = fc;
`endif
        case (state)
            S_IDLE: begin
                if (pick_valid) begin
                    gnt_nx   = pick_gnt;
                    gidx_nx  = pick_idx;
                    sof_nx   = 1'b0;
                    idle_nx  = '0;
                    state_nx = S_XFER;
                end
            end
            S_XFER: begin
                accept    = in_wr_en[gidx] & ~out_full;
                out_din   = cur;
                out_wr_en = accept;
                in_full   = ~gnt | {NIN{out_full}};
                if (accept) begin
                    idle_nx = '0;
                    if (cur[FV_BIT]) begin
                        sof_nx = 1'b1;
                    end else if (sof) begin
                        // Closing byte of a started frame: release and rotate.
                        gnt_nx   = '0;
                        rr_nx    = ptr_inc;
                        state_nx = S_IDLE;
`ifdef TXMERGE_STATS_EN
                        fc_nx[gidx] = fc[gidx] + 32'd1;
`endif
                    end
                end else begin
                    idle_nx = idle_cnt + CNT_W'(1);
                    if (idle_nx >= TIMEOUT) begin
                        // Stalled owner: drop grant; close the frame only if one was started.
                        gnt_nx   = '0;
                        rr_nx    = ptr_inc;
                        idle_nx  = '0;
                        state_nx = sof ? S_ABORT : S_IDLE;
                    end
                end
            end
            S_ABORT: begin
                out_din   = '0;
                out_wr_en = ~out_full;
                if (!out_full) begin
                    abort_nx = (abort_cnt == '1) ? abort_cnt : abort_cnt + CNT_W'(1);
                    sof_nx   = 1'b0;
                    state_nx = S_IDLE;
                end
            end
            default: begin
                state_nx = S_IDLE;
                gnt_nx   = '0;
            end
        endcase
        // Keep the write port quiet and all inputs stalled while reset is held.
        if (!sys_rst) begin
            out_wr_en = 1'b0;
            in_full   = '1;
        end
    end

    // State and control registers with synchronous active-low reset.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst) begin
            state     <= S_IDLE;
            gnt       <= '0;
            gidx      <= '0;
            rr_ptr    <= '0;
            sof       <= 1'b0;
            idle_cnt  <= '0;
            abort_cnt <= '0;
`ifdef TXMERGE_STATS_EN
            for (int unsigned i = 0; i < NIN; i++) fc[i] <= '0;
`endif
        end else begin
            state     <= state_nx;
            gnt       <= gnt_nx;
            gidx      <= gidx_nx;
            rr_ptr    <= rr_nx;
            sof       <= sof_nx;
            idle_cnt  <= idle_nx;
            abort_cnt <= abort_nx;
`ifdef TXMERGE_STATS_EN
            fc        <= fc_nx;
`endif
        end
    end

endmodule
